// File: rtl/stacker_pkg.sv
// Shared types and helpers for the block-stacker row logic.
// Holds the FSM state encoding, the playfield width default, the level
// controller's block-width constants and the width helper functions.
package stacker_pkg;

    localparam int          ROW_WIDTH_DEFAULT = 8;
    localparam int          NUM_BLOCKS_W      = 4;
    localparam int unsigned MIN_BLOCKS        = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MOVE,
        ST_EVAL,
        ST_WIN,
        ST_LOSE
    } state_t;

    // Number of set bits; callers zero-extend narrower masks to 32 bits.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

    // Requested width forced into [MIN_BLOCKS, max_w].
    function automatic int unsigned clamp_width(input logic [NUM_BLOCKS_W-1:0] n,
                                                input int unsigned max_w);
        int unsigned v;
        v = 32'(n);
        if (v < MIN_BLOCKS) v = MIN_BLOCKS;
        if (v > max_w)      v = max_w;
        return v;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Divides frame_tick by max(speed_count,1) and flags the tick that should move the row.
// Latency: step is combinational from frame_tick and the held count, so the row moves on that same edge.
// Backpressure: none; clear holds the count at zero while the row is not moving.
// Ports: clk, reset (sync, active-high), clear, frame_tick, speed_count -> step.
module step_timer #(
    parameter int SPEED_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               frame_tick,
    input  logic [SPEED_W-1:0] speed_count,
    output logic               step
);

    logic [SPEED_W-1:0] count;
    logic [SPEED_W:0]   threshold;
    logic [SPEED_W:0]   next_count;
    logic               hit;

    always_comb begin
        // A speed of zero behaves as one: every tick steps.
        threshold  = (speed_count == '0) ? (SPEED_W+1)'(1) : {1'b0, speed_count};
        next_count = {1'b0, count} + (SPEED_W+1)'(1);
        // >= rather than == so a speed lowered mid-move cannot strand the count above it.
        hit        = frame_tick && (next_count >= threshold);
        step       = hit && !clear;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (frame_tick) begin
            count <= hit ? '0 : next_count[SPEED_W-1:0];
        end
    end

endmodule

// File: rtl/row_slider.sv
// Slides a row of blocks across the playfield and scores the drop against the stack.
// Latency: go -> row visible 2 edges; drop -> next_signal/game_over 2 edges; all outputs registered.
// Backpressure: none; go outside IDLE and drop outside MOVE are ignored.
// Ports: clk, reset, frame_tick, go, drop, speed_count, num_blocks, curr_level ->
//        row_mask, stack_mask, next_signal, game_over, busy.
module row_slider
    import stacker_pkg::*;
#(
    parameter int ROW_WIDTH = ROW_WIDTH_DEFAULT,
    parameter int SPEED_W   = 6,
    parameter int LEVEL_W   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    go,
    input  logic                    drop,
    input  logic [SPEED_W-1:0]      speed_count,
    input  logic [NUM_BLOCKS_W-1:0] num_blocks,
    input  logic [LEVEL_W-1:0]      curr_level,
    output logic [ROW_WIDTH-1:0]    row_mask,
    output logic [ROW_WIDTH-1:0]    stack_mask,
    output logic                    next_signal,
    output logic                    game_over,
    output logic                    busy
);

    localparam int CW = $clog2(ROW_WIDTH + 1);

    state_t                 state;
    logic                   dir_left;   // 0: towards bit ROW_WIDTH-1
    logic [CW-1:0]          carry_w;    // width surviving the last placement
    logic                   step;
    logic                   timer_clear;
    int unsigned            load_w;
    logic [ROW_WIDTH-1:0]   load_mask;
    logic [ROW_WIDTH-1:0]   step_mask;
    logic                   step_dir_left;
    logic [ROW_WIDTH-1:0]   ov;
    logic                   row_full;

    assign timer_clear = (state != ST_MOVE);

    step_timer #(
        .SPEED_W(SPEED_W)
    ) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .frame_tick (frame_tick),
        .speed_count(speed_count),
        .step       (step)
    );

    always_comb begin
        // Beyond level 1 the row can be no wider than what survived last time.
        load_w = clamp_width(num_blocks, ROW_WIDTH);
        if (curr_level != LEVEL_W'(1) && 32'(carry_w) < load_w) begin
            load_w = 32'(carry_w);
        end
        for (int i = 0; i < ROW_WIDTH; i++) begin
            load_mask[i] = ($unsigned(i) < load_w);
        end

        // Bounce: at an edge the direction flips and the row steps back the
        // other way in the same cycle, so it never pauses at the wall.
        step_dir_left = dir_left;
        step_mask     = row_mask;
        if (!dir_left) begin
            if (row_mask[ROW_WIDTH-1]) begin
                step_dir_left = 1'b1;
                step_mask     = row_mask >> 1;
            end else begin
                step_mask     = row_mask << 1;
            end
        end else begin
            if (row_mask[0]) begin
                step_dir_left = 1'b0;
                step_mask     = row_mask << 1;
            end else begin
                step_mask     = row_mask >> 1;
            end
        end

        ov       = row_mask & stack_mask;
        row_full = &row_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            row_mask    <= '0;
            stack_mask  <= '0;
            next_signal <= 1'b0;
            game_over   <= 1'b0;
            busy        <= 1'b0;
            carry_w     <= CW'(ROW_WIDTH);
            dir_left    <= 1'b0;
        end else begin
            next_signal <= 1'b0;
            game_over   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    row_mask <= load_mask;
                    dir_left <= 1'b0;
                    state    <= ST_MOVE;
                end
                ST_MOVE: begin
                    // drop takes priority so the player scores what was on screen.
                    if (drop) begin
                        state <= ST_EVAL;
                    end else if (step && !row_full) begin
                        row_mask <= step_mask;
                        dir_left <= step_dir_left;
                    end
                end
                ST_EVAL: begin
                    if (curr_level == LEVEL_W'(1)) begin
                        stack_mask  <= row_mask;
                        carry_w     <= CW'(popcount(32'(row_mask)));
                        next_signal <= 1'b1;
                        state       <= ST_WIN;
                    end else if (ov == '0) begin
                        game_over   <= 1'b1;
                        state       <= ST_LOSE;
                    end else begin
                        stack_mask  <= ov;
                        row_mask    <= ov;
                        carry_w     <= CW'(popcount(32'(ov)));
                        next_signal <= 1'b1;
                        state       <= ST_WIN;
                    end
                end
                ST_WIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_LOSE: begin
                    stack_mask <= '0;
                    carry_w    <= CW'(ROW_WIDTH);
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_slider.sv
module tb_row_slider;

    localparam int RW = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       go = 1'b0;
    logic       drop = 1'b0;
    logic [5:0] speed_count = 6'd1;
    logic [3:0] num_blocks = 4'd1;
    logic [3:0] curr_level = 4'd1;
    logic [7:0] row_mask;
    logic [7:0] stack_mask;
    logic       next_signal;
    logic       game_over;
    logic       busy;

    row_slider dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .go         (go),
        .drop       (drop),
        .speed_count(speed_count),
        .num_blocks (num_blocks),
        .curr_level (curr_level),
        .row_mask   (row_mask),
        .stack_mask (stack_mask),
        .next_signal(next_signal),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    // Reference model: a row is a block of m_w lit columns starting at m_pos.
    logic [7:0] m_row = '0;
    logic [7:0] m_stack = '0;
    int         m_carry = RW;
    int         m_pos = 0;
    int         m_w = 1;
    int         m_spd = 1;
    int         m_ticks = 0;
    bit         m_left = 0;
    bit         m_win = 0;

    // Observations from the last drop.
    logic o_eval_busy, o_eval_pulse, o_next, o_over, o_after_pulse, o_after_busy;

    function automatic logic [7:0] mk(input int pos, input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < RW; i++) if (i >= pos && i < pos + w) r[i] = 1'b1;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_row = '0; m_stack = '0; m_carry = RW; m_ticks = 0; m_left = 0;
    endtask

    task automatic m_step();
        if (m_w < RW) begin
            if (!m_left) begin
                if (m_pos + m_w == RW) begin m_left = 1; m_pos--; end
                else m_pos++;
            end else begin
                if (m_pos == 0) begin m_left = 0; m_pos++; end
                else m_pos--;
            end
        end
        m_row = mk(m_pos, m_w);
    endtask

    task automatic m_tick();
        m_ticks++;
        if (m_ticks >= ((m_spd == 0) ? 1 : m_spd)) begin
            m_ticks = 0;
            m_step();
        end
    endtask

    task automatic start(input int lvl, input int nb, input int spd);
        curr_level = 4'(lvl); num_blocks = 4'(nb); speed_count = 6'(spd);
        go = 1'b1; cyc(); go = 1'b0; cyc();
        m_spd = spd; m_ticks = 0; m_left = 0; m_pos = 0;
        m_w = (nb == 0) ? 1 : ((nb > RW) ? RW : nb);
        if (lvl != 1 && m_carry < m_w) m_w = m_carry;
        m_row = mk(0, m_w);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            m_tick();
            if ($urandom_range(0, 1) == 1) cyc();
        end
    endtask

    task automatic drop_now(input bit with_tick);
        logic [7:0] ov;
        drop = 1'b1; frame_tick = with_tick; cyc();
        drop = 1'b0; frame_tick = 1'b0;
        o_eval_busy = busy; o_eval_pulse = next_signal | game_over;
        cyc();
        o_next = next_signal; o_over = game_over;
        cyc();
        o_after_pulse = next_signal | game_over; o_after_busy = busy;
        if (curr_level == 4'd1) begin
            m_stack = m_row; m_carry = $countones(m_row); m_win = 1;
        end else begin
            ov = m_row & m_stack;
            if (ov == '0) begin
                m_stack = '0; m_carry = RW; m_win = 0;
            end else begin
                m_stack = ov; m_row = ov; m_carry = $countones(ov); m_win = 1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc(); reset = 1'b0; m_reset();
        nchk++; if (row_mask !== 8'h00) $display("FAIL reset_row got %b exp %b", row_mask, 8'h00); else npass++;
        nchk++; if (stack_mask !== 8'h00) $display("FAIL reset_stack got %b exp %b", stack_mask, 8'h00); else npass++;
        nchk++; if ({busy, next_signal, game_over} !== 3'b000)
            $display("FAIL reset_flags got %b exp 000", {busy, next_signal, game_over}); else npass++;
    endtask

    task automatic test_sweep();
        start(1, 3, 2);
        nchk++; if (row_mask !== 8'b0000_0111) $display("FAIL sweep_load got %b exp 00000111", row_mask); else npass++;
        nchk++; if (busy !== 1'b1) $display("FAIL sweep_busy got %b exp 1", busy); else npass++;
        ticks(1);
        nchk++; if (row_mask !== 8'b0000_0111) $display("FAIL sweep_half got %b exp 00000111", row_mask); else npass++;
        ticks(9);
        nchk++; if (row_mask !== 8'b1110_0000) $display("FAIL sweep_edge got %b exp 11100000", row_mask); else npass++;
        ticks(2);
        nchk++; if (row_mask !== 8'b0111_0000) $display("FAIL sweep_bounce got %b exp 01110000", row_mask); else npass++;
        ticks(4);
        nchk++; if (row_mask !== m_row) $display("FAIL sweep_model got %b exp %b", row_mask, m_row); else npass++;
        drop_now(0);
        nchk++; if (o_eval_busy !== 1'b1 || o_eval_pulse !== 1'b0)
            $display("FAIL drop_eval got busy=%b pulse=%b exp busy=1 pulse=0", o_eval_busy, o_eval_pulse); else npass++;
        nchk++; if ({o_next, o_over} !== 2'b10) $display("FAIL drop_l1_pulse got %b exp 10", {o_next, o_over}); else npass++;
        nchk++; if (o_after_pulse !== 1'b0 || o_after_busy !== 1'b0)
            $display("FAIL drop_after got pulse=%b busy=%b exp 0 0", o_after_pulse, o_after_busy); else npass++;
        nchk++; if (stack_mask !== 8'b0001_1100) $display("FAIL drop_l1_stack got %b exp 00011100", stack_mask); else npass++;
    endtask

    task automatic test_overlap();
        start(2, 3, 1);
        ticks(3);
        nchk++; if (row_mask !== 8'b0011_1000) $display("FAIL ovl_pos got %b exp 00111000", row_mask); else npass++;
        drop_now(0);
        nchk++; if ({o_next, o_over} !== 2'b10) $display("FAIL ovl_pulse got %b exp 10", {o_next, o_over}); else npass++;
        nchk++; if (stack_mask !== 8'b0001_1000) $display("FAIL ovl_stack got %b exp 00011000", stack_mask); else npass++;
        nchk++; if (row_mask !== 8'b0001_1000) $display("FAIL ovl_row got %b exp 00011000", row_mask); else npass++;
        start(3, 3, 1);
        nchk++; if (row_mask !== 8'b0000_0011) $display("FAIL ovl_carry got %b exp 00000011", row_mask); else npass++;
        drop_now(0);
        nchk++; if ({o_next, o_over} !== 2'b01) $display("FAIL ovl_miss got %b exp 01", {o_next, o_over}); else npass++;
    endtask

    task automatic test_miss();
        start(1, 3, 1);
        drop_now(0);
        nchk++; if (stack_mask !== 8'b0000_0111) $display("FAIL miss_setup got %b exp 00000111", stack_mask); else npass++;
        start(2, 3, 1);
        ticks(5);
        nchk++; if (row_mask !== 8'b1110_0000) $display("FAIL miss_pos got %b exp 11100000", row_mask); else npass++;
        drop_now(0);
        nchk++; if ({o_next, o_over} !== 2'b01) $display("FAIL miss_pulse got %b exp 01", {o_next, o_over}); else npass++;
        nchk++; if (o_after_pulse !== 1'b0) $display("FAIL miss_single got %b exp 0", o_after_pulse); else npass++;
        nchk++; if (stack_mask !== 8'h00) $display("FAIL miss_stack got %b exp 00000000", stack_mask); else npass++;
    endtask

    task automatic test_width_speed();
        start(1, 0, 0);
        nchk++; if (row_mask !== 8'b0000_0001) $display("FAIL min_width got %b exp 00000001", row_mask); else npass++;
        ticks(3);
        nchk++; if (row_mask !== 8'b0000_1000) $display("FAIL speed0 got %b exp 00001000", row_mask); else npass++;
        go = 1'b1; cyc(); go = 1'b0; cyc();
        nchk++; if (row_mask !== 8'b0000_1000 || busy !== 1'b1)
            $display("FAIL go_ignored got row=%b busy=%b exp 00001000 1", row_mask, busy); else npass++;
        drop_now(1);
        nchk++; if (stack_mask !== 8'b0000_1000) $display("FAIL drop_wins got %b exp 00001000", stack_mask); else npass++;
        start(1, 12, 0);
        nchk++; if (row_mask !== 8'hFF) $display("FAIL sat_width got %b exp 11111111", row_mask); else npass++;
        ticks(3);
        nchk++; if (row_mask !== 8'hFF) $display("FAIL full_still got %b exp 11111111", row_mask); else npass++;
        drop_now(0);
        nchk++; if (stack_mask !== 8'hFF) $display("FAIL full_stack got %b exp 11111111", stack_mask); else npass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        start(1, 4, 1);
        ticks(2);
        reset = 1'b1; cyc(); reset = 1'b0; m_reset();
        nchk++; if (busy !== 1'b0 || row_mask !== 8'h00 || stack_mask !== 8'h00)
            $display("FAIL mid_reset got busy=%b row=%b stack=%b exp 0 0 0", busy, row_mask, stack_mask); else npass++;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drop = ($urandom_range(0, 3) == 0); frame_tick = $urandom_range(0, 1) == 1;
            cyc();
            if (next_signal | game_over | busy) seen = 1'b1;
        end
        drop = 1'b0; frame_tick = 1'b0;
        nchk++; if (seen !== 1'b0) $display("FAIL mid_quiet got %b exp 0", seen); else npass++;
    endtask

    task automatic test_random();
        int lvl;
        lvl = 1;
        for (int r = 0; r < 40; r++) begin
            start(lvl, $urandom_range(0, 12), $urandom_range(0, 3));
            nchk++; if (row_mask !== m_row) $display("FAIL rnd_load r=%0d got %b exp %b", r, row_mask, m_row); else npass++;
            for (int k = $urandom_range(0, 24); k > 0; k--) begin
                frame_tick = $urandom_range(0, 1) == 1;
                go = ($urandom_range(0, 7) == 0);
                cyc();
                if (frame_tick) m_tick();
                frame_tick = 1'b0; go = 1'b0;
                nchk++; if (row_mask !== m_row) $display("FAIL rnd_move r=%0d got %b exp %b", r, row_mask, m_row); else npass++;
            end
            drop_now($urandom_range(0, 1) == 1);
            nchk++; if ({o_next, o_over} !== {m_win, ~m_win})
                $display("FAIL rnd_result r=%0d got %b exp %b", r, {o_next, o_over}, {m_win, ~m_win}); else npass++;
            nchk++; if (stack_mask !== m_stack) $display("FAIL rnd_stack r=%0d got %b exp %b", r, stack_mask, m_stack); else npass++;
            nchk++; if (row_mask !== m_row) $display("FAIL rnd_row r=%0d got %b exp %b", r, row_mask, m_row); else npass++;
            lvl = m_win ? ((lvl < 15) ? lvl + 1 : 15) : 1;
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_overlap();
        test_miss();
        test_width_speed();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/row_slider.md
# row_slider

Horizontal mover for the block-stacker game. It takes the speed and width settings from the level controller, slides a row of lit blocks back and forth across the playfield, and evaluates the overlap against the stack when the player presses drop. Its result pulses feed back to the level controller: `next_signal` advances the level and `game_over` restarts the game. It also drives the current row and stack masks to the VGA draw stage.

## Interface
Parameters:
- `ROW_WIDTH`, default 8: playfield columns.
- `SPEED_W`, default 6: width of `speed_count`.
- `LEVEL_W`, default 4: width of `curr_level`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame (60 Hz).
- `go`  in  1  one-cycle pulse; start the current level.
- `drop`  in  1  one-cycle pulse; player drop request (already debounced).
- `speed_count`  in  SPEED_W  frames per one-column step.
- `num_blocks`  in  4  requested row width in blocks.
- `curr_level`  in  LEVEL_W  current level, 1-based.
- `row_mask`  out  ROW_WIDTH  moving row; bit 0 is the leftmost column.
- `stack_mask`  out  ROW_WIDTH  top row of the placed stack.
- `next_signal`  out  1  one-cycle pulse on a successful placement.
- `game_over`  out  1  one-cycle pulse on a miss.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, MOVE, EVAL, WIN, LOSE.
- **IDLE**
  - `row_mask` holds its last value.
  - `go` moves to LOAD.
  - `drop` is ignored.
- **LOAD** (1 cycle)
  - Effective width w = clamp(num_blocks, 1, ROW_WIDTH).
  - If `curr_level` ≠ 1, w = min(w, carry_w).
  - `row_mask` = w ones at bits [w-1:0].
  - Direction = right; frame counter = 0.
  - Next state: MOVE.
- **MOVE**
  - On `frame_tick`, the frame counter increments.
  - When counter+1 ≥ max(speed_count, 1), the counter clears and the row steps one column.
  - Moving right with bit ROW_WIDTH-1 set: reverse direction and step left in that same cycle. The mirror rule applies at bit 0.
  - If w = ROW_WIDTH, the row never moves.
  - `drop` moves to EVAL. If `drop` and a step coincide, `drop` wins: the step is suppressed and the pre-step `row_mask` is evaluated.
- **EVAL** (1 cycle)
  - Level 1: `stack_mask` ← `row_mask`; carry_w ← popcount(`row_mask`); next state WIN.
  - Otherwise, ov = `row_mask` & `stack_mask`.
  - If ov = 0: next state LOSE.
  - Else: `stack_mask` ← ov, carry_w ← popcount(ov), `row_mask` ← ov; next state WIN.
- **WIN**: `next_signal` = 1 for exactly one cycle, then IDLE.
- **LOSE**: `game_over` = 1 for exactly one cycle; `stack_mask` ← 0 and carry_w ← ROW_WIDTH; then IDLE.
- `go` arriving outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `row_mask` = 0, `stack_mask` = 0
  - `next_signal` = 0, `game_over` = 0, `busy` = 0
  - carry_w = ROW_WIDTH; frame counter 0; direction right
- Reset mid-operation: on the next edge everything takes its reset value; no result pulse is emitted.
- `go` to first visible `row_mask`: 2 edges (IDLE→LOAD, LOAD→MOVE). `row_mask` is valid from the LOAD edge.
- Step latency: `row_mask` updates on the edge that samples the qualifying `frame_tick`.
- `drop` to `next_signal`/`game_over` high: 2 edges. EVAL lasts 1 cycle; the pulse is asserted in the WIN/LOSE cycle.
- `busy` falls on the same edge that leaves WIN/LOSE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Width arithmetic:
  - The frame counter is SPEED_W bits and never wraps, because it clears at the threshold.
  - popcount result is $clog2(ROW_WIDTH+1) bits.
  - A `num_blocks` value larger than ROW_WIDTH saturates to ROW_WIDTH.

## Structure
- Shared package `stacker_pkg` holds:
  - the state enum for IDLE/LOAD/MOVE/EVAL/WIN/LOSE;
  - the ROW_WIDTH default;
  - function `popcount`;
  - function `clamp_width`.
  - The level controller's width constants move to this package as well.
- One sub-module, `step_timer`: it counts `frame_tick` pulses against `speed_count` and emits a one-cycle `step` pulse. Its inputs are `clk`, `reset`, `clear`, `frame_tick` and `speed_count`.
- The FSM, shifter and overlap logic live in `row_slider`.

## Test plan
- Reset, then `go` with level 1, `num_blocks`=3, `speed_count`=2 → `row_mask`=8'b0000_0111. It shifts left by one bit every 2nd `frame_tick`. After 5 steps it is 8'b1110_0000; the next step gives 8'b0111_0000 (bounce).
- Level 1, `drop` when `row_mask`=8'b0001_1100 → `stack_mask`=8'b0001_1100 and a single `next_signal` pulse 2 edges after `drop`.
- Level 2, `num_blocks`=3, `stack_mask`=8'b0001_1100, `drop` at `row_mask`=8'b0011_1000 → `stack_mask`=8'b0001_1000, carry_w=2. A following level-3 LOAD gives `row_mask`=8'b0000_0011.
- Level 2, `drop` at `row_mask`=8'b1110_0000 with `stack_mask`=8'b0000_0111 → one `game_over` pulse, `stack_mask`=0, no `next_signal`.
- `drop` in the same cycle as a qualifying step → the evaluated mask is the pre-step value; `num_blocks`=0 → width 1; `speed_count`=0 → a step on every tick.
- `reset` asserted during MOVE → `busy`=0 and `row_mask`=0 on the next edge. No `next_signal`/`game_over` pulses appear afterwards until a new `go` and `drop`.
